fact_sched: RTL and testbench
=============================

Name: fact_sched

Overview:
- Round-robin scheduler that shares one factorial datapath (factorial control unit plus its counter/register datapath) between NREQ requesters.
- Arbitrates requests, latches the winner's operand, and sequences the datapath through its GO/DONE handshake.
- Returns the result and an error flag to the winning requester with a one-cycle valid pulse.
- Sits between the requester-side logic and the factorial datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NW, 4, operand width in bits.
- RW, 32, result width in bits.
- MAX_N, 12, largest operand whose factorial fits in RW bits.
- TIMEOUT_CYC, 64, RUN-state cycle limit; used only when FACT_SCHED_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- REQ  in  NREQ  per-requester request level.
- N_IN  in  NREQ*NW  packed operands; requester i owns bits [i*NW +: NW].
- GNT  out  NREQ  one-hot grant; held from grant until the RESP cycle.
- RESP_VLD  out  NREQ  one-hot, one-cycle response pulse.
- RESULT  out  RW  factorial result; valid while RESP_VLD is nonzero.
- ERR  out  1  error flag; valid while RESP_VLD is nonzero.
- FACT_GO  out  1  start pulse to the datapath.
- FACT_N  out  NW  operand to the datapath; stable from START through RUN.
- FACT_DONE  in  1  datapath completion.
- FACT_RESULT  in  RW  datapath result; sampled when FACT_DONE is high.
- FACT_ABORT  out  1  datapath abort pulse; constant 0 unless timeout is compiled in.

Behaviour:
- Reset (asynchronous, RST_N low):
  - Outputs: GNT, RESP_VLD, RESULT, ERR, FACT_GO, FACT_N, FACT_ABORT all 0.
  - State IDLE, rr_ptr = 0, armed = all 1s.
  - Reset mid-operation abandons the job with no response.
- Eligibility: requester i is eligible when REQ[i] && armed[i].
  - armed[i] clears in the RESP cycle for requester i.
  - armed[i] sets on any cycle where REQ[i] == 0.
  - A requester therefore must drop REQ for at least one cycle before it can be served again. Holding REQ high does not trigger repeat service.
- Arbitration: the winner is the first eligible index at or after rr_ptr, searching upward and wrapping modulo NREQ.
  - In the RESP cycle, rr_ptr <= (idx + 1) mod NREQ.
- States:
  - IDLE: if any requester is eligible, register idx, set GNT[idx], latch FACT_N <= N_IN[idx].
    - If N_IN[idx] > MAX_N, go to RESP with ERR = 1 and RESULT = 0; the datapath is not started.
    - Otherwise go to START.
  - START: FACT_GO = 1 for exactly one cycle; go to RUN.
  - RUN: wait for FACT_DONE. When it is high, register RESULT <= FACT_RESULT and ERR <= 0, then go to RESP.
  - RESP: RESP_VLD[idx] = 1 for one cycle, GNT cleared, armed/rr_ptr updated, go to IDLE. RESULT and ERR hold until the next RESP.
- Latency:
  - Eligible REQ to RESP_VLD is 3 + D cycles, where D is the number of datapath cycles from FACT_GO to FACT_DONE.
  - An out-of-range operand gets its response in 2 cycles.
  - Back-to-back service: a new grant in the IDLE cycle immediately after RESP; no other bubble.
- Boundary conditions:
  - FACT_DONE outside RUN is ignored.
  - If REQ drops during START/RUN, the job completes and RESP_VLD is still pulsed.
  - N_IN changing after grant has no effect.
  - Simultaneous requests are resolved by rr_ptr only.
  - N = 0 is a valid operand; the expected result is 1, produced by the datapath.

Optional Feature:
- FACT_SCHED_TIMEOUT_EN defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - When the count reaches TIMEOUT_CYC without FACT_DONE: FACT_ABORT = 1 for one cycle, go to RESP with ERR = 1 and RESULT = 0.
  - If FACT_DONE and expiry occur in the same cycle, FACT_DONE wins.
- Not defined: no counter, FACT_ABORT tied to 0, RUN waits indefinitely.

Decomposition:
- Package fact_pkg holds:
  - State encoding (IDLE, START, RUN, RESP).
  - Default widths NW and RW, and default MAX_N.
  - Function fact_ovf(n) returning n > MAX_N.
- Sub-module fact_rr_pick: combinational round-robin picker.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: any_vld and winner index.
  - Reused by future shared-datapath schedulers.

Test Plan:
- Reset, then REQ[0] = 1 with N = 5 and D = 6 → GNT[0] asserted next cycle; FACT_GO pulse one cycle later with FACT_N = 5; RESP_VLD = 0001 and RESULT = 120 nine cycles after REQ; ERR = 0.
- REQ = 1111 with all N = 3 held high → grants in order 0, 1, 2, 3, each RESULT = 6, no repeats until REQ[i] is dropped for one cycle.
- rr_ptr = 2 with REQ = 0011 → requester 0 granted first, then requester 1.
- REQ[1] with N = 13 → RESP_VLD = 0010, ERR = 1, RESULT = 0 two cycles after REQ, FACT_GO never asserted.
- RST_N low during RUN → all outputs 0 immediately; a late FACT_DONE after reset is ignored; the next request is served normally.
- With FACT_SCHED_TIMEOUT_EN and TIMEOUT_CYC = 8, datapath never raises DONE → FACT_ABORT pulse then ERR = 1 response; same cycle as DONE → normal result.

Source files
------------

// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared definitions for the factorial-datapath scheduler family.
//   - fact_state_e : scheduler FSM state encoding (IDLE, START, RUN, RESP)
//   - NW_DEF/RW_DEF: default operand / result widths
//   - MAX_N_DEF    : largest operand whose factorial fits in RW_DEF bits
//   - fact_ovf()   : true when an operand would overflow the result width
// Optional feature macro used by the scheduler: FACT_SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package fact_pkg;

    localparam int NW_DEF    = 4;
    localparam int RW_DEF    = 32;
    localparam int MAX_N_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } fact_state_e;

    // Operand out of range: its factorial does not fit in the result width.
    function automatic logic fact_ovf(input int unsigned n, input int unsigned max_n);
        return (n > max_n);
    endfunction

endpackage

// File: rtl/fact_rr_pick.sv
// -----------------------------------------------------------------------------
// fact_rr_pick
// Combinational round-robin picker. Returns the first set bit of the eligible
// vector at or above the pointer, searching upward and wrapping modulo NREQ.
// Ports:
//   i_elig    [NREQ-1:0] eligible requesters
//   i_ptr     [IW-1:0]   search start index (must be < NREQ)
//   o_any_vld            at least one requester is eligible
//   o_idx     [IW-1:0]   winning index (0 when o_any_vld is low)
// -----------------------------------------------------------------------------
module fact_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_any_vld,
    output logic [IW-1:0]   o_idx
);

    // w_cand[k] is the requester index at search offset k from the pointer.
    logic [IW-1:0]   w_cand [NREQ];
    logic [NREQ-1:0] w_hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IW:0] w_sum;
        // ptr + offset never exceeds 2*NREQ-2, so one subtraction wraps it.
        assign w_sum       = {1'b0, i_ptr} + (IW+1)'(gi);
        assign w_cand[gi]  = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ))
                                                      : w_sum[IW-1:0];
        assign w_hit[gi]   = i_elig[w_cand[gi]];
    end

    // Scan from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        o_any_vld = |i_elig;
        o_idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/fact_sched.sv
// -----------------------------------------------------------------------------
// fact_sched
// Round-robin scheduler sharing one factorial datapath between NREQ
// requesters. Picks a winner, latches its operand, drives the datapath
// GO/DONE handshake and returns result + error flag with a one-cycle
// one-hot valid pulse.
//
// Optional feature: define FACT_SCHED_TIMEOUT_EN to bound the RUN state to
// TIMEOUT_CYC cycles; on expiry the datapath is aborted and the requester
// gets an error response. Without it FACT_ABORT is tied low.
//
// Ports:
//   i_clk, i_rst_n       clock / asynchronous active-low reset
//   i_req     [NREQ]     request levels
//   i_n_in    [NREQ*NW]  packed operands, requester i at [i*NW +: NW]
//   o_gnt     [NREQ]     one-hot grant, held from grant up to the RESP cycle
//   o_resp_vld[NREQ]     one-hot one-cycle response pulse
//   o_result  [RW]       factorial result, valid with o_resp_vld
//   o_err                error flag (overflow / timeout), valid with o_resp_vld
//   o_fact_go            datapath start pulse
//   o_fact_n  [NW]       datapath operand, stable from START through RUN
//   i_fact_done          datapath completion (only honoured in RUN)
//   i_fact_result [RW]   datapath result, sampled with i_fact_done
//   o_fact_abort         datapath abort pulse (timeout build only)
// -----------------------------------------------------------------------------
module fact_sched
    import fact_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int NW          = NW_DEF,
    parameter int RW          = RW_DEF,
    parameter int MAX_N       = MAX_N_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*NW-1:0] i_n_in,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_resp_vld,
    output logic [RW-1:0]      o_result,
    output logic               o_err,
    output logic               o_fact_go,
    output logic [NW-1:0]      o_fact_n,
    input  logic               i_fact_done,
    input  logic [RW-1:0]      i_fact_result,
    output logic               o_fact_abort
);

    localparam int IW = $clog2(NREQ);

    // ---------------------------------------------------------------- state
    fact_state_e     r_state;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_rr_ptr;
    logic [NREQ-1:0] r_armed;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_resp_vld;
    logic [RW-1:0]   r_result;
    logic            r_err;
    logic            r_fact_go;
    logic [NW-1:0]   r_fact_n;

    // ---------------------------------------------------------------- wires
    logic [NW-1:0]   w_n_arr [NREQ];
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_arm_clr;
    logic [NREQ-1:0] w_armed_next;
    logic [NREQ-1:0] w_win_oh;
    logic [NW-1:0]   w_n_sel;
    logic [IW-1:0]   w_win;
    logic            w_any;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign w_n_arr[gi]      = i_n_in[gi*NW +: NW];
        assign w_elig[gi]       = i_req[gi] & r_armed[gi];
        // A served requester stays disarmed until it drops its request for a
        // cycle; a low request in the RESP cycle itself already re-arms it.
        assign w_armed_next[gi] = ~i_req[gi] | (r_armed[gi] & ~w_arm_clr[gi]);
    end

    assign w_arm_clr = (r_state == ST_RESP) ? r_gnt : '0;
    assign w_win_oh  = NREQ'(1) << w_win;
    assign w_n_sel   = w_n_arr[w_win];

    fact_rr_pick #(
        .NREQ      (NREQ)
    ) u_pick (
        .i_elig    (w_elig),
        .i_ptr     (r_rr_ptr),
        .o_any_vld (w_any),
        .o_idx     (w_win)
    );

`ifdef FACT_SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0] r_tmo_cnt;
    logic           r_fact_abort;
    assign o_fact_abort = r_fact_abort;
`else
    // TIMEOUT_CYC only matters when the timeout logic is built in.
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC != 0);
    assign o_fact_abort = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_rr_ptr     <= '0;
            r_armed      <= '1;
            r_gnt        <= '0;
            r_resp_vld   <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_fact_go    <= 1'b0;
            r_fact_n     <= '0;
`ifdef FACT_SCHED_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_fact_abort <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            r_fact_go  <= 1'b0;
            r_resp_vld <= '0;
            r_armed    <= w_armed_next;
`ifdef FACT_SCHED_TIMEOUT_EN
            r_fact_abort <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx    <= w_win;
                        r_gnt    <= w_win_oh;
                        r_fact_n <= w_n_sel;
                        // Overflowing operands are answered without
                        // touching the datapath.
                        if (fact_ovf(32'(w_n_sel), 32'(MAX_N))) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_state  <= ST_START;
                        end
                    end
                end

                ST_START: begin
                    r_fact_go <= 1'b1;
`ifdef FACT_SCHED_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state   <= ST_RUN;
                end

                ST_RUN: begin
                    // DONE takes priority over a timeout expiring in the
                    // same cycle.
                    if (i_fact_done) begin
                        r_result <= i_fact_result;
                        r_err    <= 1'b0;
                        r_state  <= ST_RESP;
                    end
`ifdef FACT_SCHED_TIMEOUT_EN
                    else if (r_tmo_cnt == TCW'(TIMEOUT_CYC - 1)) begin
                        r_fact_abort <= 1'b1;
                        r_result     <= '0;
                        r_err        <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end

                ST_RESP: begin
                    r_resp_vld <= r_gnt;
                    r_gnt      <= '0;
                    r_rr_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_resp_vld = r_resp_vld;
    assign o_result   = r_result;
    assign o_err      = r_err;
    assign o_fact_go  = r_fact_go;
    assign o_fact_n   = r_fact_n;

endmodule

// File: tb/tb_fact_sched.sv
// -----------------------------------------------------------------------------
// tb_fact_sched
// Directed bench for fact_sched with a scoreboard: stimulus pushes the
// expected response, a monitor pops and compares on every RESP_VLD pulse.
// A small behavioural datapath answers FACT_GO after a programmable delay.
// Define FACT_SCHED_TIMEOUT_EN to also exercise the timeout path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fact_sched;

`ifdef FACT_SCHED_TIMEOUT_EN
    localparam int TMO       = 8;
    localparam int EXP_ABORT = 1;
`else
    localparam int TMO       = 64;
    localparam int EXP_ABORT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] n_in = '0;
    logic [3:0]  gnt;
    logic [3:0]  resp_vld;
    logic [31:0] result;
    logic        err;
    logic        fact_go;
    logic [3:0]  fact_n;
    logic        fact_done = 1'b0;
    logic [31:0] fact_result = '0;
    logic        fact_abort;

    fact_sched #(
        .NREQ        (4),
        .NW          (4),
        .RW          (32),
        .MAX_N       (12),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_n_in        (n_in),
        .o_gnt         (gnt),
        .o_resp_vld    (resp_vld),
        .o_result      (result),
        .o_err         (err),
        .o_fact_go     (fact_go),
        .o_fact_n      (fact_n),
        .i_fact_done   (fact_done),
        .i_fact_result (fact_result),
        .o_fact_abort  (fact_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_abort  = 0;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
        int          cyc;   // expected response cycle, -1 = not checked
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_resp(input int idx, input logic [31:0] res, input logic e, input int c);
        exp_t x;
        x.idx = idx;
        x.res = res;
        x.err = e;
        x.cyc = c;
        sb.push_back(x);
    endtask

    // ------------------------------------------------------------ monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (fact_abort === 1'b1) n_abort++;
            if (rst_n && resp_vld != 4'b0000) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_vld=%b, required no response", resp_vld);
                end else begin
                    e = sb.pop_front();
                    $display("[cyc %0d] resp req=%0d result=%0d err=%0b (exp req=%0d result=%0d err=%0b)",
                             cyc, $clog2(32'(resp_vld)), result, err, e.idx, e.res, e.err);
                    chk("resp_vld", 32'(resp_vld), 32'(1) << e.idx);
                    chk("result", result, e.res);
                    chk("err", 32'(err), 32'(e.err));
                    if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // ------------------------------------------------------------ datapath
    int dp_d      = 2;
    bit dp_enable = 1'b1;
    bit dp_busy   = 1'b0;
    int go_count  = 0;

    function automatic logic [31:0] fact_ref(input logic [3:0] n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    // DONE rises dp_d cycles after GO, counting the GO cycle itself.
    initial begin : datapath
        logic [3:0] n;
        forever begin
            @(negedge clk);
            if (fact_go === 1'b1) begin
                go_count++;
                if (dp_enable) begin
                    dp_busy = 1'b1;
                    n = fact_n;
                    repeat (dp_d - 1) @(posedge clk);
                    #1;
                    fact_result = fact_ref(n);
                    fact_done   = 1'b1;
                    @(posedge clk);
                    #1;
                    fact_done   = 1'b0;
                    dp_busy     = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_n(input int i, input logic [3:0] v);
        n_in[i*4 +: 4] = v;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int k = 0;
        while (sb.size() != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d responses outstanding after %0d cycles, required 0", name, sb.size(), maxc);
            sb.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},        32'(gnt), 0);
        chk({tag, "_resp_vld"},   32'(resp_vld), 0);
        chk({tag, "_result"},     result, 0);
        chk({tag, "_err"},        32'(err), 0);
        chk({tag, "_fact_go"},    32'(fact_go), 0);
        chk({tag, "_fact_n"},     32'(fact_n), 0);
        chk({tag, "_fact_abort"}, 32'(fact_abort), 0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        int k;

        // T1: reset state, then single request N=5, D=6.
        tick(1);
        chk_all_zero("rst");
        do_reset();
        dp_d = 6;
        set_n(0, 4'd5);
        req[0] = 1'b1;
        expect_resp(0, 32'd120, 1'b0, cyc + 9);
        tick(1);
        chk("t1_gnt", 32'(gnt), 32'b0001);
        chk("t1_go_early", 32'(fact_go), 0);
        tick(1);
        chk("t1_go", 32'(fact_go), 1);
        chk("t1_fact_n", 32'(fact_n), 5);
        tick(1);
        chk("t1_go_pulse", 32'(fact_go), 0);
        req[0] = 1'b0;   // dropping REQ mid-job must not cancel it
        wait_drain("t1_drain", 20);

        // T2: all four request N=3 and hold; served 0,1,2,3 once each.
        do_reset();
        dp_d = 2;
        for (int i = 0; i < 4; i++) begin
            set_n(i, 4'd3);
            expect_resp(i, 32'd6, 1'b0, -1);
        end
        req = 4'b1111;
        wait_drain("t2_drain", 60);
        tick(12);        // held requests must not be re-served
        req[2] = 1'b0;
        tick(1);
        req[2] = 1'b1;
        expect_resp(2, 32'd6, 1'b0, -1);
        wait_drain("t2_rearm", 20);
        req = '0;

        // T3: move rr_ptr to 2, then REQ=0011 -> 0 first, then 1 (N=0 -> 1).
        do_reset();
        dp_d = 3;
        set_n(1, 4'd1);
        req[1] = 1'b1;
        expect_resp(1, 32'd1, 1'b0, -1);
        wait_drain("t3_setup", 20);
        req = '0;
        tick(1);
        set_n(0, 4'd4);
        set_n(1, 4'd0);
        req = 4'b0011;
        expect_resp(0, 32'd24, 1'b0, -1);
        expect_resp(1, 32'd1, 1'b0, -1);
        tick(1);
        chk("t3_gnt", 32'(gnt), 32'b0001);
        set_n(0, 4'd7);  // operand change after grant must be ignored
        wait_drain("t3_drain", 40);
        req = '0;

        // T4: overflow operand 13, then the largest legal operand 12.
        do_reset();
        k = go_count;
        set_n(1, 4'd13);
        req[1] = 1'b1;
        expect_resp(1, 32'd0, 1'b1, cyc + 2);
        wait_drain("t4_ovf", 10);
        chk("t4_no_go", 32'(go_count), 32'(k));
        req = '0;
        tick(1);
        dp_d = 4;
        set_n(2, 4'd12);
        req[2] = 1'b1;
        expect_resp(2, 32'd479001600, 1'b0, cyc + 7);
        wait_drain("t4_max", 20);
        req = '0;

        // T5: reset during RUN, late DONE ignored, then normal service.
        do_reset();
        dp_d = 10;
        set_n(3, 4'd2);
        req[3] = 1'b1;
        k = 0;
        while (fact_go !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t5_go_seen", 32'(fact_go), 1);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        req = '0;
        tick(2);
        rst_n = 1'b1;
        k = 0;
        while (dp_busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("t5_dp_idle", 32'(dp_busy), 0);
        tick(2);
        chk("t5_late_done_result", result, 0);
        chk("t5_late_done_gnt", 32'(gnt), 0);
        dp_d = 3;
        set_n(3, 4'd4);
        req[3] = 1'b1;
        expect_resp(3, 32'd24, 1'b0, cyc + 6);
        wait_drain("t5_after", 20);
        req = '0;

`ifdef FACT_SCHED_TIMEOUT_EN
        // T6: DONE on the expiry cycle wins; a silent datapath times out.
        do_reset();
        dp_d = TMO;
        set_n(0, 4'd3);
        req[0] = 1'b1;
        expect_resp(0, 32'd6, 1'b0, -1);
        wait_drain("t6_done_wins", 30);
        req = '0;
        tick(1);
        dp_enable = 1'b0;
        set_n(1, 4'd3);
        req[1] = 1'b1;
        expect_resp(1, 32'd0, 1'b1, -1);
        wait_drain("t6_timeout", 30);
        req = '0;
        dp_enable = 1'b1;
`endif
        tick(3);
        chk("abort_pulses", 32'(n_abort), 32'(EXP_ABORT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, required finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
